uc_hazard_ctrl: RTL and testbench
=================================

# uc_hazard_ctrl

Pipeline stall controller for the EV22 control unit. Tracks the destination-register selects (SelC) of instructions in flight and detects read-after-write hazards against the decoding instruction's source selects. Sequences memory read/write strobes with a ready handshake and timeout. Drives the HOLD input of the control-unit stage registers, which then insert a bubble (SelC = 35, Type = 0).

## Interface
Parameters:
- DEPTH, 3, number of in-flight stages tracked by the scoreboard (1..6)
- REG_W, 6, width of register select fields
- NOP_SEL, 35, select value meaning "no register"; never matches a hazard
- MEM_TIMEOUT, 15, falling edges in ACCESS without MEM_READY before abort (1..255)

Ports:
- CK3  in  1  clock; all state updates on the falling edge
- RESET_N  in  1  reset, asynchronous, active-low
- SelA_in  in  REG_W  source A select of the decoding instruction
- SelB_in  in  REG_W  source B select
- UseA, UseB  in  1  source A/B is actually read
- SelC_in  in  REG_W  destination select of the decoding instruction
- MR_IN, MW_IN  in  1  decoding instruction requests a memory read/write
- MEM_READY  in  1  memory completes the current access
- HOLD  out  1  stall request to the stage registers
- MR_OUT, MW_OUT  out  1  registered memory strobes
- MEM_ERR  out  1  sticky timeout flag

## Operation
- Scoreboard pend[0..DEPTH-1], reset to NOP_SEL. Each falling edge: pend[i] <= pend[i-1]; pend[0] <= HOLD ? NOP_SEL : SelC_in.
- raw = (UseA & SelA_in != NOP_SEL & SelA_in == any pend[i]) | same for B.
- Memory FSM states:
  - IDLE: if !raw & (MR_IN | MW_IN) -> ACCESS. MW_OUT <= MW_IN; MR_OUT <= MR_IN & !MW_IN (write has priority when both are set). Timer <= 0.
  - ACCESS: strobes held. MEM_READY -> IDLE, strobes <= 0. Otherwise the timer increments. When the timer reaches MEM_TIMEOUT-1 -> IDLE, strobes <= 0, MEM_ERR <= 1.
- HOLD = raw | (state == ACCESS & !MEM_READY). HOLD is combinational from registered state and current inputs, so the stage registers see it at the same falling edge.
- MEM_ERR clears only on reset. After a timeout the faulting instruction proceeds; no retry.

## Timing
- Reset (asynchronous): pend = NOP_SEL, state IDLE, MR_OUT = MW_OUT = 0, MEM_ERR = 0, timer = 0. HOLD is forced to 0 while RESET_N = 0.
- RAW stall lasts until the producer leaves pend[DEPTH-1]: at most DEPTH edges. Bubbles are shifted in meanwhile.
- Memory strobes rise on the falling edge after request acceptance and fall on the edge where MEM_READY is sampled high. If MEM_READY is high on the first ACCESS edge, the access takes one cycle and there is no stall.
- raw and a memory request together: raw wins, FSM stays IDLE, request is re-evaluated next edge.
- MEM_READY in IDLE: ignored.
- Reset during ACCESS drops the strobes immediately (asynchronously).

## Configuration
- UC_STALL_COUNT_EN defined: adds output STALL_CNT [7:0]. It increments on every falling edge with HOLD = 1, saturates at 255, resets to 0.
- UC_STALL_COUNT_EN undefined: port and counter absent; otherwise identical behaviour.

## Structure
- Shared package uc_pkg: REG_W, NOP_SEL (35), the memory FSM state enum (IDLE, ACCESS).
- Sub-module uc_scoreboard: the pend shift register and the parallel comparators producing raw. The top level holds the FSM, timer, HOLD logic and optional counter.

## Test plan
- Reset release, no requests -> HOLD = 0, MR_OUT = MW_OUT = 0, all pend = 35.
- SelC_in = 5 on edge n, then SelA_in = 5, UseA = 1 -> HOLD high for 3 edges (DEPTH = 3) and three SelC = 35 bubbles shifted in. SelA_in = 35 -> never HOLD.
- MR_IN = 1, MEM_READY low 2 edges then high -> MR_OUT high 3 cycles, HOLD high 2 cycles, back to IDLE.
- MR_IN = MW_IN = 1 -> MW_OUT = 1, MR_OUT = 0.
- MEM_READY never asserted -> strobes drop after 15 edges, MEM_ERR = 1, stays 1 until RESET_N low.
- With UC_STALL_COUNT_EN, 300 held cycles -> STALL_CNT = 255.

Source files
------------

// File: rtl/uc_pkg.sv
// uc_pkg: shared constants and FSM state type
// for the EV22 control-unit hazard controller.
package uc_pkg;

    localparam int REG_W = 6;
    localparam logic [REG_W-1:0] NOP_SEL = 6'd35;

    typedef enum logic {
        IDLE,
        ACCESS
    } mem_state_e;

endpackage

// File: rtl/uc_scoreboard.sv
// uc_scoreboard: in-flight destination selects and
// read-after-write comparison against decode sources.
module uc_scoreboard #(
    parameter int DEPTH = 3,
    parameter int REG_W = uc_pkg::REG_W,
    parameter logic [REG_W-1:0] NOP_SEL = REG_W'(uc_pkg::NOP_SEL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic [REG_W-1:0] sel_c_i,
    input  logic [REG_W-1:0] sel_a_i,
    input  logic [REG_W-1:0] sel_b_i,
    input  logic             use_a_i,
    input  logic             use_b_i,
    output logic             raw_o
);
    import uc_pkg::*;

    logic [REG_W-1:0] pend_q [DEPTH];
    logic [REG_W-1:0] pend_d [DEPTH];
    logic             hit_a;
    logic             hit_b;

    // shift in the decoding destination, or a bubble when held
    always_comb begin
        pend_d[0] = hold ? NOP_SEL : sel_c_i;
        for (int i = 1; i < DEPTH; i++) begin
            pend_d[i] = pend_q[i-1];
        end
    end

    // scoreboard register, updated on the falling edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pend_q[i] <= NOP_SEL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    // parallel compare; a NOP source never hazards
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pend_q[i] == sel_a_i) hit_a = 1'b1;
            if (pend_q[i] == sel_b_i) hit_b = 1'b1;
        end
        raw_o = (use_a_i && (sel_a_i != NOP_SEL) && hit_a)
             || (use_b_i && (sel_b_i != NOP_SEL) && hit_b);
    end

endmodule

// File: rtl/uc_hazard_ctrl.sv
// uc_hazard_ctrl: RAW stall and memory strobe sequencer.
// Optional STALL_CNT output under UC_STALL_COUNT_EN.
module uc_hazard_ctrl #(
    parameter int DEPTH = 3,
    parameter int REG_W = uc_pkg::REG_W,
    parameter logic [REG_W-1:0] NOP_SEL = REG_W'(uc_pkg::NOP_SEL),
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             CK3,
    input  logic             RESET_N,
    input  logic [REG_W-1:0] SelA_in,
    input  logic [REG_W-1:0] SelB_in,
    input  logic             UseA,
    input  logic             UseB,
    input  logic [REG_W-1:0] SelC_in,
    input  logic             MR_IN,
    input  logic             MW_IN,
    input  logic             MEM_READY,
    output logic             HOLD,
    output logic             MR_OUT,
    output logic             MW_OUT,
    output logic             MEM_ERR
`ifdef UC_STALL_COUNT_EN
    ,
    output logic [7:0]       STALL_CNT
`endif
);
    import uc_pkg::*;

    localparam logic [7:0] TIMER_MAX = 8'(MEM_TIMEOUT - 1);

    mem_state_e state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       mr_q, mr_d;
    logic       mw_q, mw_d;
    logic       err_q, err_d;
    logic       raw;

    uc_scoreboard #(
        .DEPTH   (DEPTH),
        .REG_W   (REG_W),
        .NOP_SEL (NOP_SEL)
    ) u_sb (
        .clk     (CK3),
        .rst_n   (RESET_N),
        .hold    (HOLD),
        .sel_c_i (SelC_in),
        .sel_a_i (SelA_in),
        .sel_b_i (SelB_in),
        .use_a_i (UseA),
        .use_b_i (UseB),
        .raw_o   (raw)
    );

    // stall on hazard or on an access still waiting for memory
    always_comb begin
        HOLD = RESET_N
            && (raw || ((state_q == ACCESS) && !MEM_READY));
    end

    // memory FSM next state, strobes, timeout timer
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (!raw && (MR_IN || MW_IN)) begin
                    state_d = ACCESS;
                    mw_d    = MW_IN;
                    mr_d    = MR_IN && !MW_IN;
                    timer_d = '0;
                end
            end
            ACCESS: begin
                if (MEM_READY) begin
                    state_d = IDLE;
                    mr_d    = 1'b0;
                    mw_d    = 1'b0;
                end else if (timer_q == TIMER_MAX) begin
                    state_d = IDLE;
                    mr_d    = 1'b0;
                    mw_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM registers on the falling edge, async clear
    always_ff @(negedge CK3 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            timer_q <= '0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            err_q   <= err_d;
        end
    end

    assign MR_OUT  = mr_q;
    assign MW_OUT  = mw_q;
    assign MEM_ERR = err_q;

`ifdef UC_STALL_COUNT_EN
    logic [7:0] cnt_q, cnt_d;

    // saturating count of held edges
    always_comb begin
        cnt_d = cnt_q;
        if (HOLD && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    // stall counter register
    always_ff @(negedge CK3 or negedge RESET_N) begin
        if (!RESET_N) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign STALL_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_uc_hazard_ctrl.sv
// tb_uc_hazard_ctrl: directed bench with reference model
// for uc_hazard_ctrl; honours UC_STALL_COUNT_EN.
module tb_uc_hazard_ctrl;

    localparam int DEPTH = 3;
    localparam int NOP = 35;
    localparam int TMO = 15;

    logic       CK3 = 1'b1;
    logic       RESET_N = 1'b1;
    logic [5:0] SelA_in = 6'd35;
    logic [5:0] SelB_in = 6'd35;
    logic [5:0] SelC_in = 6'd35;
    logic       UseA = 1'b0;
    logic       UseB = 1'b0;
    logic       MR_IN = 1'b0;
    logic       MW_IN = 1'b0;
    logic       MEM_READY = 1'b0;
    logic       HOLD;
    logic       MR_OUT;
    logic       MW_OUT;
    logic       MEM_ERR;
`ifdef UC_STALL_COUNT_EN
    logic [7:0] STALL_CNT;
`endif

    uc_hazard_ctrl dut (
`ifdef UC_STALL_COUNT_EN
        .STALL_CNT (STALL_CNT),
`endif
        .CK3       (CK3),
        .RESET_N   (RESET_N),
        .SelA_in   (SelA_in),
        .SelB_in   (SelB_in),
        .UseA      (UseA),
        .UseB      (UseB),
        .SelC_in   (SelC_in),
        .MR_IN     (MR_IN),
        .MW_IN     (MW_IN),
        .MEM_READY (MEM_READY),
        .HOLD      (HOLD),
        .MR_OUT    (MR_OUT),
        .MW_OUT    (MW_OUT),
        .MEM_ERR   (MEM_ERR)
    );

    always #5 CK3 = ~CK3;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    // reference model: in-flight destinations as a queue,
    // memory access as busy flag plus waited-edge count
    int q[$];
    bit m_busy, m_rd, m_wr, m_err;
    int m_wait;
    int m_cnt;

    function automatic bit m_raw();
        bit r;
        r = 0;
        foreach (q[i]) begin
            if (UseA && SelA_in != NOP && q[i] == int'(SelA_in))
                r = 1;
            if (UseB && SelB_in != NOP && q[i] == int'(SelB_in))
                r = 1;
        end
        return r;
    endfunction

    function automatic bit m_hold();
        return RESET_N && (m_raw() || (m_busy && !MEM_READY));
    endfunction

    task automatic m_reset();
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(NOP);
        m_busy = 0;
        m_rd = 0;
        m_wr = 0;
        m_err = 0;
        m_wait = 0;
        m_cnt = 0;
    endtask

    initial m_reset();

    always @(negedge RESET_N) m_reset();

    always @(negedge CK3) begin
        if (!RESET_N) begin
            m_reset();
        end else begin
            bit h;
            bit r;
            h = m_hold();
            r = m_raw();
            if (m_busy) begin
                if (MEM_READY) begin
                    m_busy = 0;
                    m_rd = 0;
                    m_wr = 0;
                end else if (m_wait + 1 == TMO) begin
                    m_busy = 0;
                    m_rd = 0;
                    m_wr = 0;
                    m_err = 1;
                end else begin
                    m_wait++;
                end
            end else if (!r && (MR_IN || MW_IN)) begin
                m_busy = 1;
                m_wait = 0;
                m_wr = MW_IN;
                m_rd = MR_IN && !MW_IN;
            end
            q.push_front(h ? NOP : int'(SelC_in));
            void'(q.pop_back());
            if (h && m_cnt < 255) m_cnt++;
        end
    end

    // per-cycle compare, mid high phase after inputs settle
    always @(posedge CK3) begin
        #3;
        chk("hold", HOLD, m_hold());
        chk("mr_out", MR_OUT, m_rd);
        chk("mw_out", MW_OUT, m_wr);
        chk("mem_err", MEM_ERR, m_err);
`ifdef UC_STALL_COUNT_EN
        chk("stall_cnt", STALL_CNT, m_cnt);
`endif
    end

    int nh, nr, nw;

    task automatic run(input int cycles);
        nh = 0;
        nr = 0;
        nw = 0;
        repeat (cycles) begin
            #4;
            nh += int'(HOLD);
            nr += int'(MR_OUT);
            nw += int'(MW_OUT);
            @(posedge CK3);
        end
    endtask

    initial begin
        #1 RESET_N = 1'b0;
        #1;
        chk("rst_hold", HOLD, 0);
        chk("rst_mr", MR_OUT, 0);
        chk("rst_mw", MW_OUT, 0);
        chk("rst_err", MEM_ERR, 0);
        repeat (2) @(posedge CK3);
        RESET_N = 1'b1;

        SelA_in = 6'd0;
        UseA = 1'b1;
        run(3);
        chk("rst_pend_clear", nh, 0);
        UseA = 1'b0;
        SelA_in = 6'd35;

        SelC_in = 6'd5;
        run(1);
        SelC_in = 6'd35;
        SelA_in = 6'd5;
        UseA = 1'b1;
        run(6);
        chk("raw_a_edges", nh, DEPTH);

        SelA_in = 6'd35;
        run(4);
        chk("nop_never_hold", nh, 0);
        UseA = 1'b0;

        SelC_in = 6'd6;
        run(1);
        SelC_in = 6'd35;
        SelA_in = 6'd6;
        run(4);
        chk("unused_src", nh, 0);
        SelA_in = 6'd35;

        SelC_in = 6'd7;
        run(1);
        SelC_in = 6'd35;
        SelB_in = 6'd7;
        UseB = 1'b1;
        run(6);
        chk("raw_b_edges", nh, DEPTH);
        UseB = 1'b0;
        SelB_in = 6'd35;

        MR_IN = 1'b1;
        run(1);
        chk("rd_accept_hold", nh, 0);
        MR_IN = 1'b0;
        run(2);
        chk("rd_wait_hold", nh, 2);
        chk("rd_wait_mr", nr, 2);
        MEM_READY = 1'b1;
        run(1);
        chk("rd_done_hold", nh, 0);
        chk("rd_done_mr", nr, 1);
        MEM_READY = 1'b0;
        run(2);
        chk("rd_idle_mr", nr, 0);

        MR_IN = 1'b1;
        MW_IN = 1'b1;
        run(1);
        MR_IN = 1'b0;
        MW_IN = 1'b0;
        MEM_READY = 1'b1;
        run(1);
        chk("both_mw", nw, 1);
        chk("both_mr", nr, 0);
        chk("one_cycle_hold", nh, 0);
        run(3);
        chk("ready_idle", nh + nr + nw, 0);
        MEM_READY = 1'b0;

        SelC_in = 6'd9;
        run(1);
        SelC_in = 6'd35;
        SelA_in = 6'd9;
        UseA = 1'b1;
        MR_IN = 1'b1;
        run(3);
        chk("raw_wins_hold", nh, 3);
        chk("raw_wins_mr", nr, 0);
        run(1);
        MR_IN = 1'b0;
        UseA = 1'b0;
        SelA_in = 6'd35;
        MEM_READY = 1'b1;
        run(1);
        chk("retry_mr", nr, 1);
        MEM_READY = 1'b0;

        MR_IN = 1'b1;
        run(1);
        MR_IN = 1'b0;
        run(20);
        chk("tmo_mr_edges", nr, TMO);
        chk("tmo_hold_edges", nh, TMO);
        chk("tmo_err", MEM_ERR, 1);
        MW_IN = 1'b1;
        run(1);
        MW_IN = 1'b0;
        MEM_READY = 1'b1;
        run(1);
        MEM_READY = 1'b0;
        chk("err_sticky", MEM_ERR, 1);

        MW_IN = 1'b1;
        run(1);
        MW_IN = 1'b0;
        run(1);
        #1 RESET_N = 1'b0;
        #1;
        chk("arst_mw", MW_OUT, 0);
        chk("arst_err", MEM_ERR, 0);
        chk("arst_hold", HOLD, 0);
        @(posedge CK3);
        RESET_N = 1'b1;
        run(2);

`ifdef UC_STALL_COUNT_EN
        MR_IN = 1'b1;
        run(350);
        MR_IN = 1'b0;
        chk("stall_sat", STALL_CNT, 255);
        run(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
